bhg_pattern_filler: RTL and testbench
=====================================

Name: bhg_pattern_filler

Overview:
- Parametrised successor to the DECA test-pattern drawer.
- Fills a clipped rectangle of a bitmap in DDR3 with one of four patterns: solid, LFSR snow, colour bars, checkerboard.
- Issues one pixel write per accepted handshake on a DDR3 write port, with byte-lane masks for 8/16/32-bit pixels on a parametrised port width.
- Sits between the GFX command/control logic and a BrianHG_DDR3 write channel.

Parameters:
- PORT_ADDR_SIZE, 25: byte address width of the write port.
- PORT_DATA_WIDTH, 32: write data width; one of 32, 64, 128.
- LFSR_SEED, 32'hACE1_2357: snow generator reset and start value; must be non-zero.
- BAR_SHIFT, 6: colour bar width is 2^BAR_SHIFT pixels.
- CHK_SHIFT, 3: checker square size is 2^CHK_SHIFT pixels.

Ports:
- CLK  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  cancels a fill in progress.
- mode  in  2  pattern select: 0 solid, 1 snow, 2 bars, 3 checker.
- color  in  32  primary pixel colour.
- rect_x, rect_y  in  16 each  top-left corner (signed).
- rect_w, rect_h  in  16 each  size (unsigned).
- DISP_pixel_bytes  in  3  bytes per pixel: 1, 2 or 4.
- DISP_mem_addr  in  32  byte address of pixel (0,0).
- DISP_bitmap_width, DISP_bitmap_height  in  16 each  bitmap size (signed).
- write_busy_in  in  1  port backpressure.
- write_req_out  out  1  write request.
- write_adr_out  out  PORT_ADDR_SIZE  byte address.
- write_data_out  out  PORT_DATA_WIDTH  write data.
- write_mask_out  out  PORT_DATA_WIDTH/8  byte enables.
- busy  out  1  fill in progress.
- done  out  1  one-cycle completion or abort pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0.
  - FSM goes to IDLE.
  - LFSR is loaded with LFSR_SEED.
- FSM states: IDLE, SETUP, WRITE, FINISH.
- IDLE -> SETUP on start=1.
  - Latch mode, color and geometry.
  - DISP_pixel_bytes values other than 1 or 2 are treated as 4.
  - busy rises the cycle after start.
- SETUP (1 cycle):
  - Clip rectangle to [0, width-1] x [0, height-1].
  - If clipped width or height ≤ 0, go to FINISH; no writes are issued.
  - Otherwise compute start_addr = DISP_mem_addr + ((y0*width + x0) << log2(pixel_bytes)) and row stride = width << log2(pixel_bytes).
  - The multiplier is registered; SETUP may be extended to 2 cycles for timing, with no other visible effect.
- WRITE:
  - write_req_out=1 with addr, data and mask valid.
  - A write is accepted on any cycle with write_req_out=1 and write_busy_in=0.
  - While busy=1, addr, data and mask are held stable.
  - On acceptance, advance x and addr by pixel_bytes.
  - At row end, x returns to x0, y increments, and the row address advances by stride.
  - Acceptance of the last pixel goes to FINISH.
  - Back-to-back acceptance gives 1 pixel per clock.
- FINISH: done=1 and busy=0 for one cycle, then IDLE.
- abort in SETUP or WRITE:
  - write_req_out drops the same cycle; abort has priority over a concurrent acceptance.
  - Go to FINISH.
- start while busy is ignored.
- Address and truncation: all address arithmetic is done at 32 bits, then truncated to PORT_ADDR_SIZE (modulo wrap).
- Lanes, with L = log2(PORT_DATA_WIDTH/8) and lane = addr[L-1:0]:
  - Pixel = low pixel_bytes bytes of the pattern value, replicated across the whole data word.
  - Mask = ((1<<pixel_bytes)-1) << (lane aligned down to pixel_bytes).
- Patterns, with x and y as absolute bitmap coordinates:
  - solid: color.
  - snow: LFSR value (32-bit Galois, taps 0x80200003). It steps once per accepted write and is not reset between fills.
  - bars: BAR_COLORS[x[BAR_SHIFT+2:BAR_SHIFT]].
  - checker: x[CHK_SHIFT]^y[CHK_SHIFT] ? ~color : color.

Decomposition:
- Package bhg_pattern_pkg:
  - mode enum.
  - FSM state enum.
  - BAR_COLORS[8] = white, yellow, cyan, green, magenta, red, blue, black (32-bit ARGB).
  - LFSR_TAPS constant.
  - Function lanes_mask(pixel_bytes, lane).
- One natural sub-module: bhg_pattern_addr_gen (clip, start-address multiply, x/y/address stepping).
- Pattern mux and lane formatting stay in the top level.

Test Plan:
- Solid 4x2 at (10,5), pixel_bytes=4, width=2048, base 0, busy=0 -> 8 writes.
  - Addresses 0xA028, 0xA02C, 0xA030, 0xA034, 0xC028, … 0xC034; mask 0xF.
  - done is asserted 1 cycle after the 8th acceptance.
- Same fill with write_busy_in toggled 1,1,0 repeating -> same 8 writes in the same order.
  - addr, data and mask are stable while busy; no duplicate or dropped writes.
- pixel_bytes=1, rect x0=1, w=3, 32-bit port -> masks 0x2, 0x4, 0x8.
  - Data = color[7:0] replicated to all 4 bytes.
  - Repeat on a 128-bit port: masks 0x0002, 0x0004, 0x0008.
- Rect (-2,-2) 4x4 on a 2048x1080 bitmap -> clipped to 2x2 at (0,0), 4 writes.
  - Rect at (2048,0) -> no writes, done 2 cycles after start.
- Snow fill of 3 pixels -> data equals LFSR steps 1..3 from LFSR_SEED.
  - A second 3-pixel fill continues with steps 4..6.
- abort on the 3rd write while busy=1 -> req drops the same cycle, only 2 writes accepted, one done pulse.
  - reset low mid-fill clears all outputs asynchronously.

Source files
------------

// File: rtl/bhg_pattern_pkg.sv
// Shared types and constants for the pattern filler.
//   fill_mode_t   : pattern select (solid, LFSR snow, colour bars, checkerboard)
//   fill_state_t  : filler control FSM states
//   BAR_COLORS    : eight 32-bit ARGB colour-bar entries, left to right
//   LFSR_TAPS     : right-shifting Galois LFSR feedback mask for snow
//   lanes_mask()  : byte-enable pattern for a pixel at a given byte lane
package bhg_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_SNOW  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } fill_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } fill_state_t;

    localparam logic [31:0] BAR_COLORS [8] = '{
        32'hFFFF_FFFF,  // white
        32'hFFFF_FF00,  // yellow
        32'hFF00_FFFF,  // cyan
        32'hFF00_FF00,  // green
        32'hFFFF_00FF,  // magenta
        32'hFFFF_0000,  // red
        32'hFF00_00FF,  // blue
        32'hFF00_0000   // black
    };

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // pixel_bytes is 1, 2 or 4; lane is the byte offset within the data word.
    // The lane is aligned down to the pixel size before shifting the enables.
    function automatic logic [15:0] lanes_mask(input logic [2:0] pixel_bytes,
                                               input logic [3:0] lane);
        logic [3:0]  aligned;
        logic [15:0] ones;
        aligned = lane & ~(4'(pixel_bytes) - 4'd1);
        ones    = (16'd1 << pixel_bytes) - 16'd1;
        return ones << aligned;
    endfunction

endpackage

// File: rtl/bhg_pattern_addr_gen.sv
// Geometry engine for the pattern filler: latches the request, clips the
// rectangle to the bitmap, computes the start address and walks x/y/address.
//   load        : latch rectangle, bitmap size, base address and pixel size
//   setup_clip  : register clipped bounds (first SETUP cycle)
//   setup_addr  : register start address from the clipped origin (second SETUP cycle)
//   step        : advance to the next pixel after an accepted write
//   empty       : clipped rectangle has no pixels (valid from the cycle after load)
//   pix_shift   : log2 of bytes per pixel (0, 1 or 2)
//   x, y, addr  : absolute coordinates and 32-bit byte address of current pixel
//   last        : current pixel is the final one of the rectangle
module bhg_pattern_addr_gen (
    input  logic        CLK,
    input  logic        reset,
    input  logic        load,
    input  logic        setup_clip,
    input  logic        setup_addr,
    input  logic        step,
    input  logic [15:0] rect_x,
    input  logic [15:0] rect_y,
    input  logic [15:0] rect_w,
    input  logic [15:0] rect_h,
    input  logic [2:0]  pixel_bytes,
    input  logic [31:0] base_addr,
    input  logic [15:0] bitmap_w,
    input  logic [15:0] bitmap_h,
    output logic        empty,
    output logic [1:0]  pix_shift,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic [31:0] addr,
    output logic        last
);

    logic [15:0] rx_q, ry_q, rw_q, rh_q, bw_q, bh_q;
    logic [31:0] base_q;
    logic [1:0]  sh_q;
    logic [15:0] x0_q, y0_q, x_last_q, y_last_q, x_q, y_q;
    logic [31:0] addr_q, row_addr_q;

    logic signed [17:0] xs, ys, xe, ye, wl, hl, cx0, cy0, cx1, cy1;
    logic [31:0] lin_pix, start_addr, stride, pix_step;

    // Clip in 18-bit signed space: origin is signed 16, size unsigned 16,
    // so the exclusive end coordinate cannot overflow.
    always_comb begin
        xs  = {{2{rx_q[15]}}, rx_q};
        ys  = {{2{ry_q[15]}}, ry_q};
        xe  = xs + $signed({2'b00, rw_q});
        ye  = ys + $signed({2'b00, rh_q});
        wl  = {{2{bw_q[15]}}, bw_q};
        hl  = {{2{bh_q[15]}}, bh_q};
        cx0 = (xs < 18'sd0) ? 18'sd0 : xs;
        cy0 = (ys < 18'sd0) ? 18'sd0 : ys;
        cx1 = (xe > wl) ? wl : xe;
        cy1 = (ye > hl) ? hl : ye;
        empty = (cx1 <= cx0) || (cy1 <= cy0);
    end

    // Multiplier operands are registers (clipped y0 and bitmap width).
    always_comb begin
        pix_step   = 32'd1 << sh_q;
        stride     = 32'(bw_q) << sh_q;
        lin_pix    = 32'(y0_q) * 32'(bw_q) + 32'(x0_q);
        start_addr = base_q + (lin_pix << sh_q);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rx_q       <= '0;
            ry_q       <= '0;
            rw_q       <= '0;
            rh_q       <= '0;
            bw_q       <= '0;
            bh_q       <= '0;
            base_q     <= '0;
            sh_q       <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            x_last_q   <= '0;
            y_last_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            row_addr_q <= '0;
        end else begin
            if (load) begin
                rx_q   <= rect_x;
                ry_q   <= rect_y;
                rw_q   <= rect_w;
                rh_q   <= rect_h;
                bw_q   <= bitmap_w;
                bh_q   <= bitmap_h;
                base_q <= base_addr;
                sh_q   <= (pixel_bytes == 3'd1) ? 2'd0 :
                          (pixel_bytes == 3'd2) ? 2'd1 : 2'd2;
            end
            if (setup_clip) begin
                x0_q     <= cx0[15:0];
                y0_q     <= cy0[15:0];
                x_last_q <= 16'(cx1 - 18'sd1);
                y_last_q <= 16'(cy1 - 18'sd1);
                x_q      <= cx0[15:0];
                y_q      <= cy0[15:0];
            end
            if (setup_addr) begin
                addr_q     <= start_addr;
                row_addr_q <= start_addr;
            end else if (step) begin
                if (x_q == x_last_q) begin
                    x_q        <= x0_q;
                    y_q        <= y_q + 16'd1;
                    row_addr_q <= row_addr_q + stride;
                    addr_q     <= row_addr_q + stride;
                end else begin
                    x_q    <= x_q + 16'd1;
                    addr_q <= addr_q + pix_step;
                end
            end
        end
    end

    assign pix_shift = sh_q;
    assign x         = x_q;
    assign y         = y_q;
    assign addr      = addr_q;
    assign last      = (x_q == x_last_q) && (y_q == y_last_q);

endmodule

// File: rtl/bhg_pattern_filler.sv
// Fills a clipped bitmap rectangle in DDR3 with a solid, snow, colour-bar or
// checkerboard pattern, one pixel write per accepted handshake.
//   CLK, reset           : clock, asynchronous active-low reset
//   start, abort         : begin a fill (IDLE only) / cancel the fill in progress
//   mode, color          : pattern select and primary colour
//   rect_*               : rectangle origin (signed) and size (unsigned)
//   DISP_*               : pixel size, base address and bitmap dimensions
//   write_busy_in        : write port backpressure
//   write_req/adr/data/mask_out : write request with byte-lane enables
//   busy, done           : fill in progress / one-cycle completion pulse
module bhg_pattern_filler
    import bhg_pattern_pkg::*;
#(
    parameter int unsigned PORT_ADDR_SIZE  = 25,
    parameter int unsigned PORT_DATA_WIDTH = 32,
    parameter logic [31:0] LFSR_SEED       = 32'hACE1_2357,
    parameter int unsigned BAR_SHIFT       = 6,
    parameter int unsigned CHK_SHIFT       = 3
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [1:0]                   mode,
    input  logic [31:0]                  color,
    input  logic [15:0]                  rect_x,
    input  logic [15:0]                  rect_y,
    input  logic [15:0]                  rect_w,
    input  logic [15:0]                  rect_h,
    input  logic [2:0]                   DISP_pixel_bytes,
    input  logic [31:0]                  DISP_mem_addr,
    input  logic [15:0]                  DISP_bitmap_width,
    input  logic [15:0]                  DISP_bitmap_height,
    input  logic                         write_busy_in,
    output logic                         write_req_out,
    output logic [PORT_ADDR_SIZE-1:0]    write_adr_out,
    output logic [PORT_DATA_WIDTH-1:0]   write_data_out,
    output logic [PORT_DATA_WIDTH/8-1:0] write_mask_out,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned NB        = PORT_DATA_WIDTH / 8;
    localparam int unsigned LANE_BITS = $clog2(NB);

    fill_state_t state;
    fill_mode_t  mode_q;
    logic        setup_phase;
    logic [31:0] color_q;
    logic [31:0] lfsr, lfsr_next;

    logic        in_write, accept;
    logic        gen_empty, gen_last;
    logic [1:0]  gen_shift;
    logic [15:0] gen_x, gen_y;
    logic [31:0] gen_addr;

    logic [2:0]  pb_bytes;
    logic [1:0]  byte_sel_mask, byte_sel;
    logic [31:0] pix_val;
    logic [PORT_DATA_WIDTH-1:0] data_word;
    logic [15:0] full_mask;
    logic        unused_gen;

    assign in_write = (state == ST_WRITE);
    // abort wins over a same-cycle handshake: the request is withdrawn.
    assign accept   = in_write && !abort && !write_busy_in;

    // The displayed snow value is one step ahead of the register, so the
    // register only advances when the shown pixel is taken.
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

    bhg_pattern_addr_gen u_addr_gen (
        .CLK         (CLK),
        .reset       (reset),
        .load        ((state == ST_IDLE) && start),
        .setup_clip  ((state == ST_SETUP) && !setup_phase),
        .setup_addr  ((state == ST_SETUP) && setup_phase),
        .step        (accept),
        .rect_x      (rect_x),
        .rect_y      (rect_y),
        .rect_w      (rect_w),
        .rect_h      (rect_h),
        .pixel_bytes (DISP_pixel_bytes),
        .base_addr   (DISP_mem_addr),
        .bitmap_w    (DISP_bitmap_width),
        .bitmap_h    (DISP_bitmap_height),
        .empty       (gen_empty),
        .pix_shift   (gen_shift),
        .x           (gen_x),
        .y           (gen_y),
        .addr        (gen_addr),
        .last        (gen_last)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_SOLID;
            setup_phase <= 1'b0;
            color_q     <= '0;
            lfsr        <= LFSR_SEED;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_SETUP;
                        setup_phase <= 1'b0;
                        mode_q      <= fill_mode_t'(mode);
                        color_q     <= color;
                    end
                end
                ST_SETUP: begin
                    // First cycle clips; an empty result skips the address cycle.
                    if (abort) begin
                        state <= ST_FINISH;
                    end else if (!setup_phase) begin
                        if (gen_empty) state <= ST_FINISH;
                        else           setup_phase <= 1'b1;
                    end else begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (abort) begin
                        state <= ST_FINISH;
                    end else if (accept) begin
                        lfsr <= lfsr_next;
                        if (gen_last) state <= ST_FINISH;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pix_val = color_q;
        case (mode_q)
            MODE_SOLID: pix_val = color_q;
            MODE_SNOW:  pix_val = lfsr_next;
            MODE_BARS:  pix_val = BAR_COLORS[gen_x[BAR_SHIFT+2:BAR_SHIFT]];
            MODE_CHECK: pix_val = (gen_x[CHK_SHIFT] ^ gen_y[CHK_SHIFT]) ? ~color_q : color_q;
            default:    pix_val = color_q;
        endcase
    end

    // Replicate the low pixel bytes across the whole port word.
    always_comb begin
        pb_bytes      = 3'b001 << gen_shift;
        byte_sel_mask = 2'(pb_bytes - 3'd1);
        byte_sel      = '0;
        data_word     = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            byte_sel = 2'(i) & byte_sel_mask;
            data_word[8*i +: 8] = pix_val[8*byte_sel +: 8];
        end
        full_mask = lanes_mask(pb_bytes, 4'(gen_addr[LANE_BITS-1:0]));
    end

    assign write_req_out  = in_write && !abort;
    assign write_adr_out  = in_write ? gen_addr[PORT_ADDR_SIZE-1:0] : '0;
    assign write_data_out = in_write ? data_word : '0;
    assign write_mask_out = in_write ? full_mask[NB-1:0] : '0;
    assign busy           = (state == ST_SETUP) || (state == ST_WRITE);
    assign done           = (state == ST_FINISH);

    assign unused_gen = ^{gen_x, gen_y, gen_addr};

endmodule

// File: tb/tb_bhg_pattern_filler.sv
module tb_bhg_pattern_filler;

    localparam logic [31:0] SEED = 32'hACE1_2357;

    logic         CLK = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   mode = '0;
    logic [31:0]  color = '0;
    logic [15:0]  rect_x = '0, rect_y = '0, rect_w = '0, rect_h = '0;
    logic [2:0]   pbytes = 3'd4;
    logic [31:0]  base = '0;
    logic [15:0]  bw = '0, bh = '0;
    logic         wbusy = 1'b0;

    logic         a_req, a_busy, a_done;
    logic [24:0]  a_adr;
    logic [31:0]  a_data;
    logic [3:0]   a_mask;
    logic         b_req, b_busy, b_done;
    logic [24:0]  b_adr;
    logic [127:0] b_data;
    logic [15:0]  b_mask;

    always #5 CLK = ~CLK;

    bhg_pattern_filler #(.PORT_ADDR_SIZE(25), .PORT_DATA_WIDTH(32), .LFSR_SEED(SEED),
                         .BAR_SHIFT(6), .CHK_SHIFT(3)) u_dut32 (
        .CLK(CLK), .reset(reset), .start(start), .abort(abort), .mode(mode), .color(color),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .DISP_pixel_bytes(pbytes), .DISP_mem_addr(base),
        .DISP_bitmap_width(bw), .DISP_bitmap_height(bh), .write_busy_in(wbusy),
        .write_req_out(a_req), .write_adr_out(a_adr), .write_data_out(a_data),
        .write_mask_out(a_mask), .busy(a_busy), .done(a_done));

    bhg_pattern_filler #(.PORT_ADDR_SIZE(25), .PORT_DATA_WIDTH(128), .LFSR_SEED(SEED),
                         .BAR_SHIFT(6), .CHK_SHIFT(3)) u_dut128 (
        .CLK(CLK), .reset(reset), .start(start), .abort(abort), .mode(mode), .color(color),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .DISP_pixel_bytes(pbytes), .DISP_mem_addr(base),
        .DISP_bitmap_width(bw), .DISP_bitmap_height(bh), .write_busy_in(wbusy),
        .write_req_out(b_req), .write_adr_out(b_adr), .write_data_out(b_data),
        .write_mask_out(b_mask), .busy(b_busy), .done(b_done));

    typedef struct {
        logic [24:0]  adr;
        logic [31:0]  d32;
        logic [3:0]   m32;
        logic [127:0] d128;
        logic [15:0]  m128;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    int          acc_cnt = 0, acc_base = 0, last_acc_cyc = 0;
    int          busy_mode = 0, bph = 0;
    logic [31:0] m_lfsr = SEED;
    logic [31:0] bars_tbl [8] = '{32'hFFFF_FFFF, 32'hFFFF_FF00, 32'hFF00_FFFF, 32'hFF00_FF00,
                                  32'hFFFF_00FF, 32'hFFFF_0000, 32'hFF00_00FF, 32'hFF00_0000};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Reference: enumerate the clipped rectangle row by row and queue the
    // expected writes for both port widths. maxn limits how many get accepted.
    task automatic push_model(input int md, input logic [31:0] col, input int x, input int y,
                              input int w, input int h, input int pb, input logic [31:0] b,
                              input int wdt, input int hgt, input int maxn, output int n);
        int sh, pbb, x0, x1, y0, y1;
        sh  = (pb == 1) ? 0 : (pb == 2) ? 1 : 2;
        pbb = 1 << sh;
        x0  = (x < 0) ? 0 : x;
        y0  = (y < 0) ? 0 : y;
        x1  = (x + w > wdt) ? wdt : x + w;
        y1  = (y + h > hgt) ? hgt : y + h;
        n   = 0;
        if (x1 > x0 && y1 > y0) begin
            for (int yy = y0; yy < y1; yy++) begin
                for (int xx = x0; xx < x1; xx++) begin
                    if (n < maxn) begin
                        logic [31:0] a, v;
                        int l4, l16;
                        exp_t e;
                        a = b + (32'(yy * wdt + xx) << sh);
                        m_lfsr = lfsr_step(m_lfsr);
                        case (md)
                            1:       v = m_lfsr;
                            2:       v = bars_tbl[(xx / 64) % 8];
                            3:       v = (((xx / 8) + (yy / 8)) % 2 == 1) ? ~col : col;
                            default: v = col;
                        endcase
                        e.adr = a[24:0];
                        for (int i = 0; i < 16; i++) e.d128[8*i +: 8] = v[8*(i % pbb) +: 8];
                        e.d32 = e.d128[31:0];
                        l4  = int'(a % 32'd4);
                        l16 = int'(a % 32'd16);
                        e.m32  = 4'(((1 << pbb) - 1) << (l4 - l4 % pbb));
                        e.m128 = 16'(((1 << pbb) - 1) << (l16 - l16 % pbb));
                        exp_q.push_back(e);
                        n++;
                    end
                end
            end
        end
    endtask

    // Monitor: every presented write is compared with the queue head; accepted ones pop it.
    always @(negedge CLK) begin
        cyc++;
        if (reset) begin
            if (start) start_cyc = cyc;
            if (a_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (a_req && exp_q.size() > 0) begin
                chk("adr32",   a_adr,  exp_q[0].adr);
                chk("data32",  a_data, exp_q[0].d32);
                chk("mask32",  a_mask, exp_q[0].m32);
                chk("adr128",  b_adr,  exp_q[0].adr);
                chk("data128", b_data, exp_q[0].d128);
                chk("mask128", b_mask, exp_q[0].m128);
            end
            if (a_req && !wbusy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual adr=%0h required none", a_adr);
                end else begin
                    void'(exp_q.pop_front());
                end
                acc_cnt++;
                last_acc_cyc = cyc;
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        case (busy_mode)
            1: begin wbusy = ((bph % 3) != 2); bph++; end
            2: wbusy = 1'($urandom_range(0, 1));
            3: wbusy = ((acc_cnt - acc_base) >= 2);
            default: wbusy = 1'b0;
        endcase
    end

    task automatic launch(input int md, input logic [31:0] col, input int x, input int y,
                          input int w, input int h, input int pb, input logic [31:0] b,
                          input int wdt, input int hgt, input int bmode, input int maxn,
                          output int n, output int d0);
        push_model(md, col, x, y, w, h, pb, b, wdt, hgt, maxn, n);
        @(posedge CLK);
        #2;
        busy_mode = bmode;
        bph = 0;
        mode = 2'(md); color = col;
        rect_x = 16'(x); rect_y = 16'(y); rect_w = 16'(w); rect_h = 16'(h);
        pbytes = 3'(pb); base = b; bw = 16'(wdt); bh = 16'(hgt);
        acc_base = acc_cnt;
        d0 = done_cnt;
        start = 1'b1;
        @(posedge CLK);
        #2;
        start = 1'b0;
    endtask

    // lat: 1 = done one cycle after last acceptance, 2 = done two cycles after start.
    task automatic run_fill(input string tag, input int md, input logic [31:0] col,
                            input int x, input int y, input int w, input int h, input int pb,
                            input logic [31:0] b, input int wdt, input int hgt,
                            input int bmode, input bit do_abort, input int lat);
        int n, d0;
        bit got, found;
        launch(md, col, x, y, w, h, pb, b, wdt, hgt, bmode, do_abort ? 2 : 1 << 30, n, d0);
        if (do_abort) begin
            found = 1'b0;
            for (int k = 0; k < 200 && !found; k++) begin
                @(negedge CLK);
                #1;
                if (a_req && wbusy && (acc_cnt - acc_base) == 2) found = 1'b1;
            end
            if (!found) begin
                checks++; errors++;
                $display("FAIL %s abort_window actual=timeout required=third write held", tag);
            end
            abort = 1'b1;
            #1;
            chk({tag, " abort_req32"}, a_req, 0);
            chk({tag, " abort_req128"}, b_req, 0);
            @(posedge CLK);
            #2;
            abort = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(posedge CLK);
            if (done_cnt != d0) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s done_wait actual=timeout required=done pulse", tag);
        end
        repeat (3) @(posedge CLK);
        chk({tag, " done_pulses"}, done_cnt - d0, 1);
        chk({tag, " writes"}, acc_cnt - acc_base, n);
        chk({tag, " leftover"}, exp_q.size(), 0);
        if (lat == 1) chk({tag, " done_latency"}, done_cyc - last_acc_cyc, 1);
        if (lat == 2) chk({tag, " empty_latency"}, done_cyc - start_cyc, 2);
        exp_q.delete();
        busy_mode = 0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pbs[6] = '{1, 2, 4, 0, 3, 7};
        int n, d0, wdt, hgt;
        bit got;

        #2 reset = 1'b0;
        #2;
        chk("rst req32", a_req, 0);   chk("rst busy32", a_busy, 0); chk("rst done32", a_done, 0);
        chk("rst adr32", a_adr, 0);   chk("rst data32", a_data, 0); chk("rst mask32", a_mask, 0);
        chk("rst req128", b_req, 0);  chk("rst data128", b_data, 0); chk("rst mask128", b_mask, 0);
        repeat (3) @(posedge CLK);
        #2 reset = 1'b1;

        run_fill("snow1", 1, 32'h0, 0, 0, 3, 1, 4, 32'h100, 64, 64, 0, 1'b0, 1);
        run_fill("snow2", 1, 32'h0, 5, 2, 3, 1, 4, 32'h100, 64, 64, 0, 1'b0, 1);
        run_fill("solid", 0, 32'h1234_5678, 10, 5, 4, 2, 4, 32'h0, 2048, 1080, 0, 1'b0, 1);
        run_fill("solid_bp", 0, 32'h1234_5678, 10, 5, 4, 2, 4, 32'h0, 2048, 1080, 1, 1'b0, 1);
        run_fill("pb1", 0, 32'h1122_3344, 1, 0, 3, 1, 1, 32'h0, 2048, 1080, 0, 1'b0, 1);
        run_fill("pb2", 0, 32'hA5B6_C7D8, 3, 1, 5, 2, 2, 32'h40, 100, 50, 1, 1'b0, 1);
        run_fill("pb3as4", 0, 32'hCAFE_F00D, 1, 1, 2, 2, 3, 32'h8, 16, 16, 0, 1'b0, 1);
        run_fill("clip", 0, 32'h00FF_00FF, -2, -2, 4, 4, 4, 32'h0, 2048, 1080, 0, 1'b0, 1);
        run_fill("empty", 0, 32'h0, 2048, 0, 4, 4, 4, 32'h0, 2048, 1080, 0, 1'b0, 2);
        run_fill("bars", 2, 32'h0, 60, 3, 10, 1, 4, 32'h1000, 200, 10, 0, 1'b0, 1);
        run_fill("checker", 3, 32'h0F0F_3C3C, 6, 6, 4, 4, 2, 32'h200, 64, 64, 2, 1'b0, 1);
        run_fill("abort", 0, 32'h5555_AAAA, 10, 5, 4, 2, 4, 32'h0, 2048, 1080, 3, 1'b1, 0);

        for (int r = 0; r < 14; r++) begin
            wdt = int'($urandom_range(8, 80));
            hgt = int'($urandom_range(4, 20));
            run_fill("rand", int'($urandom_range(0, 3)), $urandom(),
                     int'($urandom_range(0, 14)) - 6 + int'($urandom_range(0, 1)) * (wdt - 4),
                     int'($urandom_range(0, 10)) - 4,
                     int'($urandom_range(0, 9)), int'($urandom_range(0, 5)),
                     pbs[$urandom_range(0, 5)], $urandom(), wdt, hgt, 2, 1'b0, 0);
        end

        // Reset in the middle of a fill.
        launch(0, 32'h7777_8888, 0, 0, 10, 10, 4, 32'h0, 64, 64, 1, 1 << 30, n, d0);
        got = 1'b0;
        for (int k = 0; k < 500 && !got; k++) begin
            @(posedge CLK);
            if ((acc_cnt - acc_base) >= 3) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL midreset_wait actual=timeout required=3 writes");
        end
        #2 reset = 1'b0;
        #1;
        chk("midrst req32", a_req, 0);   chk("midrst busy32", a_busy, 0);
        chk("midrst done32", a_done, 0); chk("midrst adr32", a_adr, 0);
        chk("midrst data32", a_data, 0); chk("midrst mask32", a_mask, 0);
        chk("midrst req128", b_req, 0);  chk("midrst mask128", b_mask, 0);
        exp_q.delete();
        m_lfsr = SEED;
        busy_mode = 0;
        repeat (2) @(posedge CLK);
        #2 reset = 1'b1;

        run_fill("snow_after_rst", 1, 32'h0, 0, 0, 3, 1, 4, 32'h0, 16, 16, 0, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
